// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard controller: mul/div FSM states,
// the hardwired-zero register index and the default mul/div latency.
package hazard_unit_pkg;

    typedef enum logic [0:0] {
        HZ_IDLE,
        HZ_BUSY
    } hz_state_t;

    localparam logic [4:0]  REG_ZERO              = 5'd0;
    localparam int unsigned MULDIV_CYCLES_DEFAULT = 32;

endpackage

// File: rtl/muldiv_busy_ctr.sv
// Busy tracker for the multi-cycle multiply/divide unit. An accepted start keeps
// busy_o high for exactly MULDIV_CYCLES cycles; a start while busy is ignored.
module muldiv_busy_ctr
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic start_i,
    output logic busy_o
);

    localparam int unsigned CntW = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(MULDIV_CYCLES - 1);

    hz_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_o  = 1'b0;
        unique case (state_q)
            HZ_IDLE: begin
                if (start_i) begin
                    state_d = HZ_BUSY;
                    cnt_d   = CntLoad;
                end
            end
            HZ_BUSY: begin
                busy_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = HZ_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = HZ_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HZ_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the five-stage pipeline: load-use bubble, taken-branch
// flush, optional mul/div busy interlock (HAZARD_MULDIV_EN) and a stall-cycle counter.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  ra_pipe_id,
    input  logic [4:0]  rb_pipe_id,
    input  logic        UsesA_id,
    input  logic        UsesB_id,
    input  logic        MemToReg_pipe_ex,
    input  logic        RegWrite_pipe_ex,
    input  logic [4:0]  RegWriteDst_pipe_ex,
    input  logic        BranchTaken_ex,
    input  logic        MulDivStart_id,
    input  logic        MulDivRead_id,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        MulDivBusy,
    output logic [31:0] StallCount
);

    logic        load_use;
    logic        md_haz;
    logic [31:0] stall_count_q, stall_count_d;

    assign load_use = RegWrite_pipe_ex && MemToReg_pipe_ex && (RegWriteDst_pipe_ex != REG_ZERO) &&
                      ((UsesA_id && (ra_pipe_id == RegWriteDst_pipe_ex)) ||
                       (UsesB_id && (rb_pipe_id == RegWriteDst_pipe_ex)));

`ifdef HAZARD_MULDIV_EN
    logic md_start_ok;

    // A start counts only if the ID instruction actually advances this cycle.
    assign md_start_ok = MulDivStart_id && !BranchTaken_ex && !load_use && !md_haz;
    assign md_haz      = MulDivBusy && (MulDivStart_id || MulDivRead_id);

    muldiv_busy_ctr #(
        .MULDIV_CYCLES(MULDIV_CYCLES)
    ) u_muldiv_busy_ctr (
        .clock  (clock),
        .reset  (reset),
        .start_i(md_start_ok),
        .busy_o (MulDivBusy)
    );
`else
    logic unused_md;

    assign unused_md  = MulDivStart_id ^ MulDivRead_id;
    assign md_haz     = 1'b0;
    assign MulDivBusy = 1'b0;
`endif

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        if (reset) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (BranchTaken_ex) begin
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (load_use || md_haz) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!PCWrite && !reset && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with MULDIV_CYCLES=4; mul/div checks depend on
// whether HAZARD_MULDIV_EN is defined for the build.
module tb_hazard_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  ra_pipe_id, rb_pipe_id, RegWriteDst_pipe_ex;
    logic        UsesA_id, UsesB_id, MemToReg_pipe_ex, RegWrite_pipe_ex;
    logic        BranchTaken_ex, MulDivStart_id, MulDivRead_id;
    logic        PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivBusy;
    logic [31:0] StallCount;

    int checks = 0;
    int errors = 0;

    hazard_unit #(
        .MULDIV_CYCLES(4)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .ra_pipe_id         (ra_pipe_id),
        .rb_pipe_id         (rb_pipe_id),
        .UsesA_id           (UsesA_id),
        .UsesB_id           (UsesB_id),
        .MemToReg_pipe_ex   (MemToReg_pipe_ex),
        .RegWrite_pipe_ex   (RegWrite_pipe_ex),
        .RegWriteDst_pipe_ex(RegWriteDst_pipe_ex),
        .BranchTaken_ex     (BranchTaken_ex),
        .MulDivStart_id     (MulDivStart_id),
        .MulDivRead_id      (MulDivRead_id),
        .PCWrite            (PCWrite),
        .IFIDWrite          (IFIDWrite),
        .IFIDFlush          (IFIDFlush),
        .IDEXBubble         (IDEXBubble),
        .MulDivBusy         (MulDivBusy),
        .StallCount         (StallCount)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the four enables as a packed {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble}.
    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, PCWrite, IFIDWrite, IFIDFlush, IDEXBubble}, {28'd0, exp});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ra_pipe_id          = 5'd0;
        rb_pipe_id          = 5'd0;
        UsesA_id            = 1'b0;
        UsesB_id            = 1'b0;
        MemToReg_pipe_ex    = 1'b0;
        RegWrite_pipe_ex    = 1'b0;
        RegWriteDst_pipe_ex = 5'd0;
        BranchTaken_ex      = 1'b0;
        MulDivStart_id      = 1'b0;
        MulDivRead_id       = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] dst, input logic mem);
        MemToReg_pipe_ex    = mem;
        RegWrite_pipe_ex    = 1'b1;
        RegWriteDst_pipe_ex = dst;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        check_ctl("reset_ctl", 4'b0011);
        tick();
        tick();
        check("reset_count", StallCount, 32'd0);
        check("reset_busy", {31'd0, MulDivBusy}, 32'd0);
        reset = 1'b0;
        #1;
        check_ctl("idle_ctl", 4'b1100);

        // lw $8 in EX, add reading $8 via ra
        set_load(5'd8, 1'b1);
        ra_pipe_id = 5'd8;
        UsesA_id   = 1'b1;
        #1;
        check_ctl("loaduse_a_ctl", 4'b0001);
        tick();
        check("loaduse_a_count", StallCount, 32'd1);
        // bubble now in EX
        MemToReg_pipe_ex    = 1'b0;
        RegWrite_pipe_ex    = 1'b0;
        RegWriteDst_pipe_ex = 5'd0;
        #1;
        check_ctl("after_bubble_ctl", 4'b1100);
        tick();
        check("after_bubble_count", StallCount, 32'd1);

        // $0 never stalls
        set_load(5'd0, 1'b1);
        ra_pipe_id = 5'd0;
        #1;
        check_ctl("reg0_ctl", 4'b1100);
        // non-load writer is forwarded
        set_load(5'd8, 1'b0);
        ra_pipe_id = 5'd8;
        #1;
        check_ctl("alu_fwd_ctl", 4'b1100);
        // matching ra but not used
        set_load(5'd8, 1'b1);
        UsesA_id = 1'b0;
        #1;
        check_ctl("unused_a_ctl", 4'b1100);
        // rb path
        rb_pipe_id = 5'd8;
        UsesB_id   = 1'b1;
        ra_pipe_id = 5'd3;
        #1;
        check_ctl("loaduse_b_ctl", 4'b0001);
        tick();
        check("loaduse_b_count", StallCount, 32'd2);

        // branch overrides load-use
        BranchTaken_ex = 1'b1;
        #1;
        check_ctl("branch_ctl", 4'b1111);
        tick();
        check("branch_count", StallCount, 32'd2);
        idle_inputs();
        #1;

`ifdef HAZARD_MULDIV_EN
        // mult accepted at edge 0, mflo in ID from cycle 1
        MulDivStart_id = 1'b1;
        #1;
        check_ctl("mult_issue_ctl", 4'b1100);
        tick();
        MulDivStart_id = 1'b0;
        MulDivRead_id  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("md_busy_c%0d", i), {31'd0, MulDivBusy}, 32'd1);
            check_ctl($sformatf("md_stall_c%0d", i), 4'b0001);
            tick();
        end
        check("md_busy_c5", {31'd0, MulDivBusy}, 32'd0);
        check_ctl("md_go_c5", 4'b1100);
        check("md_count", StallCount, 32'd6);
        MulDivRead_id = 1'b0;

        // start squashed by branch
        BranchTaken_ex = 1'b1;
        MulDivStart_id = 1'b1;
        tick();
        check("md_squash_busy", {31'd0, MulDivBusy}, 32'd0);
        BranchTaken_ex = 1'b0;
        tick();
        check("md_restart_busy", {31'd0, MulDivBusy}, 32'd1);
        MulDivStart_id = 1'b0;
        // branch in BUSY does not cancel the countdown
        BranchTaken_ex = 1'b1;
        tick();
        BranchTaken_ex = 1'b0;
        check("md_busy_cycle2", {31'd0, MulDivBusy}, 32'd1);
`else
        MulDivRead_id  = 1'b1;
        MulDivStart_id = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("nomd_busy_%0d", i), {31'd0, MulDivBusy}, 32'd0);
            check_ctl($sformatf("nomd_ctl_%0d", i), 4'b1100);
            tick();
        end
        check("nomd_count", StallCount, 32'd2);
        MulDivStart_id = 1'b0;
`endif

        // reset mid-operation
        reset = 1'b1;
        #1;
        check_ctl("midreset_ctl", 4'b0011);
        tick();
        reset = 1'b0;
        MulDivRead_id = 1'b0;
        #1;
        check("midreset_busy", {31'd0, MulDivBusy}, 32'd0);
        check("midreset_count", StallCount, 32'd0);
        check_ctl("post_reset_ctl", 4'b1100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage MIPS core; the stall and flush counterpart to the operand-forwarding logic. It detects the load-use case that forwarding cannot satisfy and inserts one bubble. It redirects on taken branches resolved in EX. It tracks a multi-cycle multiply/divide unit with a busy counter, and keeps a saturating stall-cycle performance counter. It drives the PC register, the IF/ID register and the ID/EX register enables.

## Interface

Parameters:
- MULDIV_CYCLES, 32, latency of a multiply/divide in cycles (legal range 2..64).

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ra_pipe_id  in  5  source register A of the instruction in ID
- rb_pipe_id  in  5  source register B of the instruction in ID
- UsesA_id  in  1  instruction in ID actually reads ra
- UsesB_id  in  1  instruction in ID actually reads rb
- MemToReg_pipe_ex  in  1  instruction in EX is a load
- RegWrite_pipe_ex  in  1  instruction in EX writes the register file
- RegWriteDst_pipe_ex  in  5  destination register of the instruction in EX
- BranchTaken_ex  in  1  branch/jump in EX resolved taken
- MulDivStart_id  in  1  instruction in ID is mult/multu/div/divu
- MulDivRead_id  in  1  instruction in ID is mfhi/mflo
- PCWrite  out  1  PC register enable
- IFIDWrite  out  1  IF/ID register enable
- IFIDFlush  out  1  IF/ID register loads a NOP
- IDEXBubble  out  1  ID/EX register loads a NOP (control zeroed)
- MulDivBusy  out  1  multiply/divide result not yet available
- StallCount  out  32  cycles in which PCWrite was 0 outside reset, saturating

## Operation

- LoadUse = RegWrite_pipe_ex & MemToReg_pipe_ex & (RegWriteDst_pipe_ex != 0) & ((UsesA_id & ra_pipe_id == RegWriteDst_pipe_ex) | (UsesB_id & rb_pipe_id == RegWriteDst_pipe_ex)).
- MdHaz = MulDivBusy & (MulDivStart_id | MulDivRead_id).
- Priority, highest first:
  - reset: PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1.
  - BranchTaken_ex: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXBubble=1. This overrides any stall condition, and the ID instruction is not accepted.
  - LoadUse or MdHaz: PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXBubble=1.
  - Otherwise: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.
- A load-use hazard stalls exactly one cycle. After that cycle the bubble occupies EX, and the MEM-stage forwarding path supplies the operand.
- Register $0 never causes a stall.
- FSM states:
  - IDLE: MulDivBusy=0. Moves to BUSY when MulDivStart_id is accepted, meaning no branch flush, no LoadUse and the instruction is not held; the counter loads MULDIV_CYCLES-1.
  - BUSY: MulDivBusy=1. The counter decrements each cycle. At count 0 with no new start, the FSM returns to IDLE on the next edge.
- A start in BUSY is always stalled by MdHaz, so there is no restart path.
- StallCount increments when PCWrite==0 and reset==0, and saturates at 32'hFFFF_FFFF.

## Timing

- The hazard outputs are combinational from the current inputs and registered state, with zero latency, and must settle within the ID-stage cycle.
- The FSM, counter and StallCount update on the rising edge of clock.
- Reset values: state IDLE, counter 0, MulDivBusy=0, StallCount=0. The hazard outputs take the reset row above.
- Reset asserted mid-BUSY returns to IDLE on the next edge, and the in-flight operation is abandoned.
- With mult accepted at edge N, MulDivBusy is 1 for cycles N+1 through N+MULDIV_CYCLES. mfhi in ID is stalled in those cycles and proceeds in cycle N+MULDIV_CYCLES+1.
- BranchTaken_ex together with MulDivStart_id: the start is squashed and the FSM stays in IDLE.
- BranchTaken_ex in BUSY does not cancel the busy countdown.

## Configuration

- HAZARD_MULDIV_EN defined: FSM, counter and MdHaz are present as described.
- HAZARD_MULDIV_EN undefined:
  - MulDivStart_id and MulDivRead_id remain as ports but are ignored.
  - MulDivBusy is tied 0 and MdHaz is 0.
  - No FSM or counter registers are generated; StallCount remains.

## Structure

- The shared pipeline package holds:
  - the hz_state_t enum {HZ_IDLE, HZ_BUSY};
  - the localparam REG_ZERO = 5'd0;
  - the default MULDIV_CYCLES constant.
- One sub-module, muldiv_busy_ctr, holds the FSM and counter (start, busy). It is instantiated only under HAZARD_MULDIV_EN.
- Hazard equations and StallCount live in hazard_unit.

## Test plan

- lw writes $8 in EX (MemToReg=1, RegWrite=1, Dst=8), add in ID with ra=8, UsesA=1 -> PCWrite=0, IFIDWrite=0, IDEXBubble=1 for exactly one cycle; StallCount goes 0→1.
- Same as above but Dst=0, ra=0 -> no stall. Also Dst=8 with MemToReg=0 -> no stall, because forwarding covers it.
- LoadUse and BranchTaken_ex=1 in the same cycle -> PCWrite=1, IFIDFlush=1, IDEXBubble=1, and StallCount is unchanged.
- MULDIV_CYCLES=4, mult accepted at edge 0, mflo in ID from cycle 1 -> MulDivBusy=1 and stall in cycles 1–4, mflo proceeds in cycle 5, StallCount=4.
- Reset asserted in cycle 2 of BUSY -> next edge MulDivBusy=0, StallCount=0; during reset PCWrite=0 and IFIDFlush=1.
- Build without HAZARD_MULDIV_EN, MulDivRead_id=1 held -> MulDivBusy=0 and never any stall.
